// File: rtl/t03_hud_pkg.sv
// Shared types and glyph constants for the HUD digit scheduler.
// Tens-digit blanking is applied only when T03_HUD_LEADING_BLANK_EN is defined (see top).
package t03_hud_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DECODE  = 2'd1,
        WR_TENS = 2'd2,
        WR_ONES = 2'd3
    } hud_state_t;

    localparam logic [5:0] GLYPH_DIGIT0 = 6'd26;
    localparam logic [5:0] GLYPH_BLANK  = 6'd3;

    // A zero tens digit becomes a blank tile when blanking is enabled.
    function automatic logic [5:0] tens_glyph(input logic [5:0] g, input logic blank_en);
        return (blank_en && (g == GLYPH_DIGIT0)) ? GLYPH_BLANK : g;
    endfunction

endpackage

// File: rtl/t03_rr_arbiter.sv
// Round-robin grant selection: first set req bit searching upward from rr_ptr+1.
// Purely combinational; the scheduler registers the chosen index.
module t03_rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    input  logic                       en,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
    output logic                       gnt_valid
);

    localparam int IDX_W = $clog2(NUM_REQ);

    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        if (en) begin
            // Offset NUM_REQ wraps back to rr_ptr itself, so it has lowest priority.
            for (int i = 1; i <= NUM_REQ; i++) begin
                if (!gnt_valid && req[(int'(rr_ptr) + i) % NUM_REQ]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
                end
            end
        end
    end

endmodule

// File: rtl/t03_hud_digit_scheduler.sv
// Time-shares one binary->two-glyph decoder among HUD requesters and writes tens/ones tiles.
// Define T03_HUD_LEADING_BLANK_EN to write a blank tile instead of a leading zero tens digit.
module t03_hud_digit_scheduler
    import t03_hud_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_W      = 8,
    parameter int BASE_ADDR   = 0,
    parameter int SLOT_STRIDE = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [4*NUM_REQ-1:0]   value,
    output logic [NUM_REQ-1:0]     ack,
    output logic                   busy,
    output logic [3:0]             dec_bin,
    input  logic [11:0]            dec_glyph,
    output logic                   wr_en,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic [5:0]             wr_data,
    input  logic                   wr_ready
);

    localparam int IDX_W = $clog2(NUM_REQ);

`ifdef T03_HUD_LEADING_BLANK_EN
    localparam logic BLANK_EN = 1'b1;
`else
    localparam logic BLANK_EN = 1'b0;
`endif

    hud_state_t          state_q, state_d;
    logic [IDX_W-1:0]    gnt_q, gnt_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [3:0]          dec_bin_q, dec_bin_d;
    logic [11:0]         glyph_q, glyph_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [5:0]          wr_data_q, wr_data_d;

    logic [IDX_W-1:0]    arb_idx;
    logic                arb_valid;

    t03_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req       (req),
        .rr_ptr    (rr_ptr_q),
        .en        (state_q == IDLE),
        .gnt_idx   (arb_idx),
        .gnt_valid (arb_valid)
    );

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        rr_ptr_d  = rr_ptr_q;
        dec_bin_d = dec_bin_q;
        glyph_d   = glyph_q;
        wr_en_d   = wr_en_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    gnt_d     = arb_idx;
                    dec_bin_d = value[4*int'(arb_idx) +: 4];
                    state_d   = DECODE;
                end
            end
            DECODE: begin
                // The tens tile is presented in the cycle glyph_q becomes valid, so take it from the decoder.
                glyph_d   = dec_glyph;
                wr_en_d   = 1'b1;
                wr_addr_d = ADDR_W'(BASE_ADDR + int'(gnt_q) * SLOT_STRIDE);
                wr_data_d = tens_glyph(dec_glyph[11:6], BLANK_EN);
                state_d   = WR_TENS;
            end
            WR_TENS: begin
                if (wr_ready) begin
                    wr_addr_d = wr_addr_q + ADDR_W'(1);
                    wr_data_d = glyph_q[5:0];
                    state_d   = WR_ONES;
                end
            end
            WR_ONES: begin
                if (wr_ready) begin
                    wr_en_d  = 1'b0;
                    rr_ptr_d = gnt_q;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            rr_ptr_q  <= IDX_W'(NUM_REQ - 1);
            dec_bin_q <= '0;
            glyph_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            rr_ptr_q  <= rr_ptr_d;
            dec_bin_q <= dec_bin_d;
            glyph_q   <= glyph_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_comb begin
        ack = '0;
        if ((state_q == WR_ONES) && wr_ready) begin
            ack[gnt_q] = 1'b1;
        end
    end

    assign busy    = (state_q != IDLE);
    assign dec_bin = dec_bin_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

endmodule

// File: tb/tb_t03_hud_digit_scheduler.sv
// Directed bench for t03_hud_digit_scheduler: vector table plus hand-written multi-cycle sequences.
// Expected tens glyph for a leading-zero value follows T03_HUD_LEADING_BLANK_EN.
module tb_t03_hud_digit_scheduler;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 8;
`ifdef T03_HUD_LEADING_BLANK_EN
    localparam int TZ = 3;
`else
    localparam int TZ = 26;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NUM_REQ-1:0]   req = '0;
    logic [4*NUM_REQ-1:0] value = '0;
    logic [NUM_REQ-1:0]   ack;
    logic                 busy;
    logic [3:0]           dec_bin;
    logic [11:0]          dec_glyph;
    logic                 wr_en;
    logic [ADDR_W-1:0]    wr_addr;
    logic [5:0]           wr_data;
    logic                 wr_ready = 1'b1;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    typedef struct { int cyc; int addr; int data; } wr_rec_t;
    typedef struct { int cyc; int vec; } ack_rec_t;
    typedef struct { int idx; int val; int ta; int td; int oa; int od; } vec_t;

    wr_rec_t     wlog[$];
    ack_rec_t    alog[$];
    logic [13:0] exp_q[$];
    int          exp_ack_q[$];
    vec_t        vecs[6];

    t03_hud_digit_scheduler #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .BASE_ADDR(0), .SLOT_STRIDE(2)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .value(value), .ack(ack), .busy(busy),
        .dec_bin(dec_bin), .dec_glyph(dec_glyph), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_ready(wr_ready)
    );

    // Reference BCD decoder: glyph 26 is digit 0.
    always_comb begin
        dec_glyph = {6'(26 + int'(dec_bin) / 10), 6'(26 + int'(dec_bin) % 10)};
    end

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && wr_en && wr_ready) wlog.push_back('{cyc, int'(wr_addr), int'(wr_data)});
        if (!rst && (ack != '0)) alog.push_back('{cyc, int'(ack)});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exhausted");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        req = '0;
        tick();
        tick();
        rst = 1'b0;
        wlog.delete();
        alog.delete();
    endtask

    task automatic set_val(input int i, input int v);
        value[4*i +: 4] = 4'(v);
    endtask

    task automatic push_exp(input int addr, input int data);
        exp_q.push_back({8'(addr), 6'(data)});
    endtask

    // Run until n acks are logged, dropping each requester's req once it is acked.
    task automatic run_acks(input int n, input string name);
        int k;
        k = 0;
        while ((alog.size() < n) && (k < 60)) begin
            tick();
            foreach (alog[j]) req = req & ~NUM_REQ'(alog[j].vec);
            k++;
        end
        check({name, "_ack_count"}, alog.size(), n);
    endtask

    task automatic drain(input string name);
        logic [13:0] e;
        int ea;
        check({name, "_wr_count"}, wlog.size(), exp_q.size());
        foreach (wlog[j]) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({name, "_addr"}, wlog[j].addr, int'(e[13:6]));
                check({name, "_data"}, wlog[j].data, int'(e[5:0]));
            end
        end
        foreach (alog[j]) begin
            if (exp_ack_q.size() > 0) begin
                ea = exp_ack_q.pop_front();
                check({name, "_ack_vec"}, alog[j].vec, ea);
            end
        end
        exp_q.delete();
        exp_ack_q.delete();
        wlog.delete();
        alog.delete();
    endtask

    initial begin
        int t0;
        int k;

        vecs[0] = '{1, 12, 2, 27, 3, 28};
        vecs[1] = '{3, 15, 6, 27, 7, 31};
        vecs[2] = '{2,  5, 4, TZ, 5, 31};
        vecs[3] = '{0,  9, 0, TZ, 1, 35};
        vecs[4] = '{3, 10, 6, 27, 7, 26};
        vecs[5] = '{2,  0, 4, TZ, 5, 26};

        // Reset state, sampled while reset is asserted.
        #1;
        check("rst_ack", ack, 0);
        check("rst_busy", busy, 0);
        check("rst_dec_bin", dec_bin, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        reset_dut();

        // Cycle-exact single service of value 7.
        set_val(0, 7);
        req = 4'b0001;
        t0 = cyc;
        tick();
        check("t1_dec_bin", dec_bin, 7);
        check("t1_busy", busy, 1);
        run_acks(1, "t1");
        check("t1_wcount", wlog.size(), 2);
        if (wlog.size() >= 2) begin
            check("t1_tens_cyc", wlog[0].cyc, t0 + 2);
            check("t1_ones_cyc", wlog[1].cyc, t0 + 3);
        end
        if (alog.size() >= 1) check("t1_ack_cyc", alog[0].cyc, t0 + 3);
        push_exp(0, TZ); push_exp(1, 33); exp_ack_q.push_back(1);
        drain("t1");

        // Vector table: single requester services.
        foreach (vecs[i]) begin
            set_val(vecs[i].idx, vecs[i].val);
            req = NUM_REQ'(1 << vecs[i].idx);
            push_exp(vecs[i].ta, vecs[i].td);
            push_exp(vecs[i].oa, vecs[i].od);
            exp_ack_q.push_back(1 << vecs[i].idx);
            run_acks(1, "vec");
            drain("vec");
        end

        // Simultaneous requests and round-robin order.
        reset_dut();
        set_val(0, 3);
        set_val(1, 8);
        req = 4'b0011;
        push_exp(0, TZ); push_exp(1, 29); push_exp(2, TZ); push_exp(3, 34);
        exp_ack_q.push_back(1); exp_ack_q.push_back(2);
        run_acks(2, "rr_first");
        drain("rr_first");
        req = 4'b0001;
        push_exp(0, TZ); push_exp(1, 29); exp_ack_q.push_back(1);
        run_acks(1, "rr_solo");
        drain("rr_solo");
        req = 4'b0011;
        push_exp(2, TZ); push_exp(3, 34); push_exp(0, TZ); push_exp(1, 29);
        exp_ack_q.push_back(2); exp_ack_q.push_back(1);
        run_acks(2, "rr_ptr0");
        drain("rr_ptr0");

        // wr_ready stall in WR_TENS, plus a short req pulse that must never be served.
        set_val(2, 4);
        wr_ready = 1'b0;
        req = 4'b0100;
        k = 0;
        while (!wr_en && (k < 10)) begin
            tick();
            k++;
        end
        check("stall_wr_en_seen", wr_en, 1);
        req[3] = 1'b1;
        for (int s = 0; s < 3; s++) begin
            tick();
            req[3] = 1'b0;
            check("stall_wr_en", wr_en, 1);
            check("stall_addr", wr_addr, 4);
            check("stall_data", wr_data, TZ);
            check("stall_no_accept", wlog.size(), 0);
        end
        wr_ready = 1'b1;
        push_exp(4, TZ); push_exp(5, 30); exp_ack_q.push_back(4);
        run_acks(1, "stall");
        if (wlog.size() >= 2) check("stall_ones_after", wlog[1].cyc, wlog[0].cyc + 1);
        for (int s = 0; s < 8; s++) tick();
        check("drop_before_grant_acks", alog.size(), 1);
        drain("stall");

        // Reset during WR_ONES aborts without ack; held req is served again.
        set_val(1, 3);
        req = 4'b0010;
        k = 0;
        while ((wlog.size() < 1) && (k < 10)) begin
            tick();
            k++;
        end
        check("rst_mid_in_ones", wr_en, 1);
        rst = 1'b1;
        #1;
        check("rst_mid_wr_en", wr_en, 0);
        check("rst_mid_ack", ack, 0);
        check("rst_mid_busy", busy, 0);
        tick();
        rst = 1'b0;
        check("rst_mid_no_ack", alog.size(), 0);
        wlog.delete();
        push_exp(2, TZ); push_exp(3, 29); exp_ack_q.push_back(2);
        run_acks(1, "rst_retry");
        drain("rst_retry");

        // value changes after grant must not affect tiles in flight.
        set_val(2, 9);
        req = 4'b0100;
        tick();
        set_val(2, 4);
        check("late_val_dec_bin", dec_bin, 9);
        push_exp(4, TZ); push_exp(5, 35); exp_ack_q.push_back(4);
        run_acks(1, "late_val");
        drain("late_val");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
